// File: rtl/money_display_scan.sv
// money_display_scan
//
// Converts a 5-bit credit value (0..31) to two BCD digits with a sequential
// double-dabble converter. The digits are shown on a 6-digit multiplexed
// 7-segment display that is scanned right to left.
//
// Ports
//   CLK       in   single clock, rising edge
//   RSTB      in   asynchronous active-low reset
//   MONEY_IN  in   [4:0] credit value, registered before any use
//   DISP_EN   in   1 = display on, 0 = blanked (scan keeps running)
//   DIGIT     out  [5:0] active-low one-hot digit select, bit 0 = rightmost
//   SEG       out  [6:0] active-high segments {A,B,C,D,E,F,G}
//   SEG_DP    out  decimal point, always 0
//   BUSY      out  high while the converter is in CONV or LOAD

module money_display_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RSTB,
    input  logic [4:0] MONEY_IN,
    input  logic       DISP_EN,
    output logic [5:0] DIGIT,
    output logic [6:0] SEG,
    output logic       SEG_DP,
    output logic       BUSY
);

    localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StLoad = 2'd2
    } state_t;

    // Converter state
    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_in_q;
    logic [4:0]  r_last_val;
    logic [4:0]  w_last_val_next;
    logic [4:0]  r_conv_val;
    logic [4:0]  w_conv_val_next;
    // {tens[3:0], ones[3:0], binary[4:0]}
    logic [12:0] r_shift;
    logic [12:0] w_shift_next;
    logic [12:0] w_adj;
    logic [2:0]  r_iter;
    logic [2:0]  w_iter_next;
    logic [3:0]  r_tens;
    logic [3:0]  w_tens_next;
    logic [3:0]  r_ones;
    logic [3:0]  w_ones_next;

    // Scan state
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_next;
    logic               w_presc_wrap;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic [5:0]         r_digit;
    logic [5:0]         w_digit_next;
    logic [6:0]         r_seg;
    logic [6:0]         w_seg_next;

    function automatic logic [6:0] seg7(input logic [3:0] val);
        logic [6:0] code;
        unique case (val)
            4'd0:    code = 7'b1111110;
            4'd1:    code = 7'b0110000;
            4'd2:    code = 7'b1101101;
            4'd3:    code = 7'b1111001;
            4'd4:    code = 7'b0110011;
            4'd5:    code = 7'b1011011;
            4'd6:    code = 7'b1011111;
            4'd7:    code = 7'b1110010;
            4'd8:    code = 7'b1111111;
            4'd9:    code = 7'b1111011;
            default: code = 7'b0000000;
        endcase
        return code;
    endfunction

    // One double-dabble step: adjust BCD nibbles >= 5, shift happens in the FSM.
    always_comb begin
        w_adj = r_shift;
        if (r_shift[12:9] >= 4'd5) w_adj[12:9] = r_shift[12:9] + 4'd3;
        if (r_shift[8:5]  >= 4'd5) w_adj[8:5]  = r_shift[8:5]  + 4'd3;
    end

    // Converter next-state logic
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_iter_next     = r_iter;
        w_conv_val_next = r_conv_val;
        w_last_val_next = r_last_val;
        w_tens_next     = r_tens;
        w_ones_next     = r_ones;
        unique case (r_state)
            StIdle: begin
                if (r_in_q != r_last_val) begin
                    w_state_next    = StConv;
                    w_shift_next    = {8'd0, r_in_q};
                    w_iter_next     = 3'd0;
                    // Snapshot so later input changes cannot disturb this run.
                    w_conv_val_next = r_in_q;
                end
            end
            StConv: begin
                w_shift_next = {w_adj[11:0], 1'b0};
                w_iter_next  = r_iter + 3'd1;
                if (r_iter == 3'd4) w_state_next = StLoad;
            end
            StLoad: begin
                // Both digits move together so the display never mixes values.
                w_tens_next     = r_shift[12:9];
                w_ones_next     = r_shift[8:5];
                w_last_val_next = r_conv_val;
                w_state_next    = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Scan next-state and registered display outputs
    always_comb begin
        w_presc_wrap = (r_presc == PRESC_MAX);
        w_presc_next = w_presc_wrap ? '0 : r_presc + 1'b1;
        w_idx_next   = r_idx;
        if (w_presc_wrap) w_idx_next = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;

        w_digit_next = 6'b111111;
        w_seg_next   = 7'b0000000;
        if (DISP_EN) begin
            w_digit_next = ~(6'b000001 << r_idx);
            unique case (r_idx)
                3'd0:    w_seg_next = seg7(r_ones);
                3'd1:    w_seg_next = (r_tens == 4'd0) ? 7'b0000000 : seg7(r_tens);
                default: w_seg_next = 7'b0000000;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_in_q     <= 5'd0;
            r_last_val <= 5'd0;
            r_conv_val <= 5'd0;
            r_shift    <= 13'd0;
            r_iter     <= 3'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_presc    <= '0;
            r_idx      <= 3'd0;
            r_digit    <= 6'b111111;
            r_seg      <= 7'b0000000;
        end else begin
            r_in_q     <= MONEY_IN;
            r_last_val <= w_last_val_next;
            r_conv_val <= w_conv_val_next;
            r_shift    <= w_shift_next;
            r_iter     <= w_iter_next;
            r_tens     <= w_tens_next;
            r_ones     <= w_ones_next;
            r_presc    <= w_presc_next;
            r_idx      <= w_idx_next;
            r_digit    <= w_digit_next;
            r_seg      <= w_seg_next;
        end
    end

    assign DIGIT  = r_digit;
    assign SEG    = r_seg;
    assign SEG_DP = 1'b0;
    assign BUSY   = (r_state == StConv) || (r_state == StLoad);

endmodule

// File: tb/tb_money_display_scan.sv
// tb_money_display_scan
//
// Directed bench for money_display_scan with SCAN_DIV = 4. Checks reset
// values, the scan sequence, conversion latency and BUSY width, input changes
// during a conversion, display blanking, reset mid-conversion and a full sweep
// of all credit values.

module tb_money_display_scan;

    logic       CLK;
    logic       RSTB;
    logic [4:0] MONEY_IN;
    logic       DISP_EN;
    logic [5:0] DIGIT;
    logic [6:0] SEG;
    logic       SEG_DP;
    logic       BUSY;

    int n_tests;
    int n_fail;

    logic [6:0] seg_tab [10];

    // Free-running scan reference: index and the index currently shown.
    int m_presc;
    int m_idx;
    int m_shown;

    money_display_scan #(
        .SCAN_DIV (4)
    ) dut (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .MONEY_IN (MONEY_IN),
        .DISP_EN  (DISP_EN),
        .DIGIT    (DIGIT),
        .SEG      (SEG),
        .SEG_DP   (SEG_DP),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            m_presc <= 0;
            m_idx   <= 0;
            m_shown <= 0;
        end else begin
            m_shown <= m_idx;
            if (m_presc == 3) begin
                m_presc <= 0;
                m_idx   <= (m_idx == 5) ? 0 : m_idx + 1;
            end else begin
                m_presc <= m_presc + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_digit(input int idx, input string tag);
        logic [5:0] target;
        logic       found;
        target = ~(6'b000001 << idx);
        found  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (DIGIT == target) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        logic [5:0] exp_digit;
        logic       found;
        n_tests = 0;
        n_fail  = 0;
        seg_tab[0] = 7'b1111110;
        seg_tab[1] = 7'b0110000;
        seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001;
        seg_tab[4] = 7'b0110011;
        seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111;
        seg_tab[7] = 7'b1110010;
        seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1111011;

        RSTB     = 1'b1;
        MONEY_IN = 5'd0;
        DISP_EN  = 1'b1;
        #2 RSTB  = 1'b0;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_digit", 32'(DIGIT), 32'h3f);
        check("rst_seg", 32'(SEG), 32'h0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_dp", 32'(SEG_DP), 32'd0);
        check("rst_tens", 32'(dut.r_tens), 32'd0);
        check("rst_ones", 32'(dut.r_ones), 32'd0);
        RSTB = 1'b1;

        // Scan sequence from release: each digit held 4 cycles, "0" on digit 0
        for (int k = 1; k <= 48; k++) begin
            int idx;
            @(negedge CLK);
            idx       = ((k - 1) / 4) % 6;
            exp_digit = ~(6'b000001 << idx);
            check("scan_digit", 32'(DIGIT), 32'(exp_digit));
            check("scan_seg", 32'(SEG), (idx == 0) ? 32'h7e : 32'h0);
            check("scan_dp", 32'(SEG_DP), 32'd0);
        end

        // 0 -> 23: BUSY for 6 cycles, display regs update on the 8th edge
        MONEY_IN = 5'd23;
        for (int e = 1; e <= 8; e++) begin
            @(negedge CLK);
            check("c23_busy", 32'(BUSY), (e >= 2 && e <= 7) ? 32'd1 : 32'd0);
            if (e == 7) begin
                check("c23_tens_early", 32'(dut.r_tens), 32'd0);
                check("c23_ones_early", 32'(dut.r_ones), 32'd0);
            end
        end
        check("c23_tens", 32'(dut.r_tens), 32'd2);
        check("c23_ones", 32'(dut.r_ones), 32'd3);
        wait_digit(1, "c23_wait_d1");
        check("c23_seg_d1", 32'(SEG), 32'(7'b1101101));
        wait_digit(0, "c23_wait_d0");
        check("c23_seg_d0", 32'(SEG), 32'(7'b1111001));

        // 31, then 9 while converting: 31 lands first, then 9 is picked up
        MONEY_IN = 5'd31;
        for (int e = 1; e <= 15; e++) begin
            @(negedge CLK);
            if (e == 2) check("c31_busy", 32'(BUSY), 32'd1);
            if (e == 3) MONEY_IN = 5'd9;
            if (e == 8) begin
                check("c31_tens", 32'(dut.r_tens), 32'd3);
                check("c31_ones", 32'(dut.r_ones), 32'd1);
                check("c31_idle", 32'(BUSY), 32'd0);
            end
            if (e == 9) check("c9_busy", 32'(BUSY), 32'd1);
            if (e == 14) check("c9_ones_early", 32'(dut.r_ones), 32'd1);
        end
        check("c9_tens", 32'(dut.r_tens), 32'd0);
        check("c9_ones", 32'(dut.r_ones), 32'd9);
        check("c9_busy_done", 32'(BUSY), 32'd0);
        wait_digit(1, "c9_wait_d1");
        check("c9_seg_d1", 32'(SEG), 32'd0);
        wait_digit(0, "c9_wait_d0");
        check("c9_seg_d0", 32'(SEG), 32'(7'b1111011));

        // Display blanked for 10 cycles; scan continues underneath
        DISP_EN = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge CLK);
            check("blank_digit", 32'(DIGIT), 32'h3f);
            check("blank_seg", 32'(SEG), 32'h0);
        end
        DISP_EN = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge CLK);
            exp_digit = ~(6'b000001 << m_shown);
            check("resume_digit", 32'(DIGIT), 32'(exp_digit));
        end

        // Reset during the 3rd CONV cycle of 0 -> 17
        MONEY_IN = 5'd0;
        repeat (10) @(negedge CLK);
        MONEY_IN = 5'd17;
        repeat (4) @(negedge CLK);
        check("r17_busy_pre", 32'(BUSY), 32'd1);
        RSTB = 1'b0;
        #2;
        check("r17_busy_rst", 32'(BUSY), 32'd0);
        check("r17_digit_rst", 32'(DIGIT), 32'h3f);
        check("r17_seg_rst", 32'(SEG), 32'h0);
        @(negedge CLK);
        check("r17_tens_rst", 32'(dut.r_tens), 32'd0);
        check("r17_ones_rst", 32'(dut.r_ones), 32'd0);
        RSTB = 1'b1;
        @(negedge CLK);
        check("r17_tens_rel", 32'(dut.r_tens), 32'd0);
        check("r17_ones_rel", 32'(dut.r_ones), 32'd0);
        check("r17_busy_rel", 32'(BUSY), 32'd0);
        found = 1'b0;
        for (int e = 2; e <= 8; e++) begin
            @(negedge CLK);
            if (dut.r_tens == 4'd1 && dut.r_ones == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        check("r17_reconv", 32'(found), 32'd1);

        // Sweep every credit value
        for (int v = 0; v < 32; v++) begin
            MONEY_IN = 5'(v);
            repeat (10) @(negedge CLK);
            check("sweep_tens", 32'(dut.r_tens), 32'(v / 10));
            check("sweep_ones", 32'(dut.r_ones), 32'(v % 10));
            check("sweep_busy", 32'(BUSY), 32'd0);
            wait_digit(0, "sweep_wait_d0");
            check("sweep_seg_d0", 32'(SEG), 32'(seg_tab[v % 10]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
